// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic GNT_A = 1'b0;
    localparam logic GNT_B = 1'b1;

    localparam int DEF_TIMEOUT = 15;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between port A and port B. Build option MEM_ARB_RR_EN
// selects round-robin on contention; otherwise port A has fixed priority.
module mem_arb_pick
    import mem_ctrl_pkg::*;
(
    input  logic i_aReq,
    input  logic i_bReq,
    input  logic i_lastGnt,
    output logic o_valid,
    output logic o_gnt
);

    assign o_valid = i_aReq | i_bReq;

`ifdef MEM_ARB_RR_EN
    // On contention the port that was not granted last time wins.
    always_comb begin
        o_gnt = GNT_A;
        if (i_aReq && i_bReq) begin
            o_gnt = (i_lastGnt == GNT_A) ? GNT_B : GNT_A;
        end else if (!i_aReq) begin
            o_gnt = GNT_B;
        end
    end
`else
    logic w_unusedLastGnt;
    assign w_unusedLastGnt = i_lastGnt;
    assign o_gnt           = i_aReq ? GNT_A : GNT_B;
`endif

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequencer/arbiter sharing one handshaked data memory between the MEM-stage
// port (A) and a loader/debug port (B). Build option: MEM_ARB_RR_EN.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic [DW-1:0] a_rdata,
    output logic          a_done,
    output logic          stall,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic [DW-1:0] b_rdata,
    output logic          b_done,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          err
);

    localparam int            CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT);

    state_t        r_state;
    state_t        w_stateNext;
    logic          r_gnt;
    logic          r_lastGnt;
    logic          r_we;
    logic [CW-1:0] r_cnt;

    logic          w_arbValid;
    logic          w_arbGnt;
    logic          w_take;
    logic          w_finish;
    logic          w_timeout;
    logic [CW-1:0] w_cntInc;
    logic          w_selWe;
    logic [AW-1:0] w_selAddr;
    logic [DW-1:0] w_selWdata;
    logic [DW-1:0] w_capData;

    mem_arb_pick u_arb (
        .i_aReq    (a_req),
        .i_bReq    (b_req),
        .i_lastGnt (r_lastGnt),
        .o_valid   (w_arbValid),
        .o_gnt     (w_arbGnt)
    );

    assign w_selWe    = (w_arbGnt == GNT_B) ? b_we    : a_we;
    assign w_selAddr  = (w_arbGnt == GNT_B) ? b_addr  : a_addr;
    assign w_selWdata = (w_arbGnt == GNT_B) ? b_wdata : a_wdata;
    assign w_cntInc   = r_cnt + CW'(1);
    assign w_capData  = w_timeout ? '0 : mem_rdata;

    // a_done is registered, so the stall falls in the completion cycle itself.
    assign stall = a_req & ~a_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_take      = 1'b0;
        w_finish    = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_arbValid) begin
                    w_take      = 1'b1;
                    w_stateNext = ISSUE;
                end
            end
            ISSUE: begin
                w_stateNext = WAIT;
            end
            WAIT: begin
                // A ready arriving in the last allowed cycle still wins over the abort.
                if (mem_ready) begin
                    w_finish    = 1'b1;
                    w_stateNext = RESP;
                end else if (w_cntInc == CNT_LIMIT) begin
                    w_finish    = 1'b1;
                    w_timeout   = 1'b1;
                    w_stateNext = RESP;
                end
            end
            RESP: begin
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt     <= GNT_A;
            r_lastGnt <= GNT_B;
            r_we      <= 1'b0;
            r_cnt     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            a_rdata   <= '0;
            b_rdata   <= '0;
            a_done    <= 1'b0;
            b_done    <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            a_done <= 1'b0;
            b_done <= 1'b0;

            if (w_take) begin
                r_gnt     <= w_arbGnt;
                r_lastGnt <= w_arbGnt;
                r_we      <= w_selWe;
                r_cnt     <= '0;
                mem_en    <= 1'b1;
                mem_we    <= w_selWe;
                mem_addr  <= w_selAddr;
                mem_wdata <= w_selWdata;
            end

            if (r_state == WAIT) begin
                r_cnt <= w_cntInc;
            end

            // Completion: done and, for loads only, the port's read data.
            if (w_finish) begin
                if (r_gnt == GNT_B) begin
                    b_done <= 1'b1;
                    if (!r_we) begin
                        b_rdata <= w_capData;
                    end
                end else begin
                    a_done <= 1'b1;
                    if (!r_we) begin
                        a_rdata <= w_capData;
                    end
                end
            end

            if (w_timeout) begin
                err <= 1'b1;
            end
        end
    end

endmodule
